dipsw_debounce_ctrl: RTL and testbench

DIPSW_DEBOUNCE_CTRL -- requirements
Module: dipsw_debounce_ctrl

---
 rtl/dipsw_debounce_ctrl_if.sv | 19 +
 rtl/dipsw_debounce_ctrl.sv | 127 ++++++++++++
 tb/tb_dipsw_debounce_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dipsw_debounce_ctrl_if.sv
// Avalon-MM slave bus for the DIP-switch debounce controller.
// The host drives address and strobes; the controller returns registered readdata.
interface dipsw_debounce_ctrl_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata
    );
endinterface

// File: rtl/dipsw_debounce_ctrl.sv
// DIP-switch debouncer with per-bit stability counters, an init window that
// suppresses edge capture, and an Avalon-MM register block with masked level irq.
module dipsw_debounce_ctrl #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    dipsw_debounce_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]      in_port,
    output logic                  irq
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int INIT_W = $clog2(DEBOUNCE_CYCLES + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [WIDTH-1:0]    sync1_q, sync2_q;
    logic [WIDTH-1:0]    deb_q, deb_d;
    logic [CNT_W-1:0]    cnt_q [WIDTH];
    logic [CNT_W-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [WIDTH-1:0]    edge_q, edge_d;
    logic [31:0]         readdata_q, readdata_d;
    logic                irq_q;

    // Upper write-data bits have no register behind them.
    logic unused_wdata;
    assign unused_wdata = ^bus.writedata;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_LAST) state_d = RUN;
                else                         init_cnt_d = init_cnt_q + INIT_W'(1);
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // A counter only advances while the synchronized input disagrees with deb;
    // any agreement restarts the window, so short glitches never commit.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge set wins over write-1-clear on the same bit.
    always_comb begin
        logic [WIDTH-1:0] edge_set;
        logic [WIDTH-1:0] edge_clr;
        logic [31:0]      rd_mux;

        edge_set = (deb_d ^ deb_q) & {WIDTH{state_q == RUN}};
        edge_clr = '0;
        mask_d   = mask_q;
        if (bus.write && bus.address == ADDR_EDGE) edge_clr = bus.writedata[WIDTH-1:0];
        if (bus.write && bus.address == ADDR_MASK) mask_d   = bus.writedata[WIDTH-1:0];
        edge_d = (edge_q & ~edge_clr) | edge_set;

        rd_mux = '0;
        case (bus.address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = deb_q;
            ADDR_RAW:  rd_mux[WIDTH-1:0] = sync2_q;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask_q;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edge_q;
            default:   rd_mux = '0;
        endcase
        readdata_d = bus.read ? rd_mux : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            mask_q     <= '0;
            edge_q     <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
            // NOTE: the counter array is plain flops, not a RAM, so each entry is reset to drop partial counts.
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            mask_q     <= mask_d;
            edge_q     <= edge_d;
            readdata_q <= readdata_d;
            irq_q      <= |(edge_q & mask_q);
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_dipsw_debounce_ctrl.sv
// Self-checking bench for dipsw_debounce_ctrl (WIDTH=4, DEBOUNCE_CYCLES=8);
// read expectations go through a scoreboard queue and are popped when readdata is valid.
module tb_dipsw_debounce_ctrl;

    localparam int W = 4;
    localparam int D = 8;

    localparam logic [1:0] A_DATA = 2'd0;
    localparam logic [1:0] A_RAW  = 2'd1;
    localparam logic [1:0] A_MASK = 2'd2;
    localparam logic [1:0] A_EDGE = 2'd3;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic         irq;

    dipsw_debounce_ctrl_if bus ();

    dipsw_debounce_ctrl #(
        .WIDTH           (W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];

    // Advance past n rising edges, landing 1 time unit after the last one.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sb_pop_compare();
        logic [31:0] e;
        string       nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        n_cmp++;
        if (bus.readdata !== e) begin
            n_err++;
            $display("FAIL %s: readdata=%h expected=%h", nm, bus.readdata, e);
        end
    endtask

    task automatic do_read(input logic [1:0] addr, input logic [31:0] exp, input string nm);
        bus.address = addr;
        bus.read    = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        tick();
        bus.read = 1'b0;
        sb_pop_compare();
    endtask

    task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address   = addr;
        bus.writedata = data;
        bus.write     = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic test_reset();
        tick(2);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: irq=%b expected=0", irq); end
        n_cmp++;
        if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL reset_rd: readdata=%h expected=0", bus.readdata); end
        reset_n = 1'b1;
        // Switches 1010 held through release: deb commits on the 10th clock, inside INIT.
        tick(9);
        do_read(A_DATA, 32'h0, "init_data_before");
        do_read(A_DATA, 32'hA, "init_data_settled");
        do_read(A_EDGE, 32'h0, "init_edge");
        do_read(A_RAW,  32'hA, "init_raw");
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL init_irq: irq=%b expected=0", irq); end
        tick();
        n_cmp++;
        if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL idle_rd: readdata=%h expected=0", bus.readdata); end
    endtask

    task automatic test_rise();
        in_port = 4'b1011;
        tick(9);
        do_read(A_DATA, 32'hA, "rise_one_early");
        do_read(A_DATA, 32'hB, "rise_exact");
        do_read(A_EDGE, 32'h1, "rise_edge");
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rise_irq_masked: irq=%b expected=0", irq); end
    endtask

    task automatic test_glitch();
        // Bit2 pulses high and bit1 pulses low for 5 clocks.
        in_port = 4'b1101;
        tick(3);
        do_read(A_RAW, 32'hD, "glitch_raw");
        tick();
        in_port = 4'b1011;
        tick(12);
        do_read(A_DATA, 32'hB, "glitch_data");
        do_read(A_EDGE, 32'h1, "glitch_edge");
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL glitch_irq: irq=%b expected=0", irq); end
    endtask

    task automatic test_irq();
        do_write(A_MASK, 32'h1);
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_same_cycle: irq=%b expected=0", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_after_mask: irq=%b expected=1", irq); end
        do_write(A_EDGE, 32'h1);
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL irq_clear_same: irq=%b expected=1", irq); end
        tick();
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL irq_after_clear: irq=%b expected=0", irq); end
        do_read(A_EDGE, 32'h0, "edge_cleared");
    endtask

    task automatic test_simul_clear();
        in_port = 4'b1111;
        tick(9);
        // This write lands on the same edge bit2 commits.
        do_write(A_EDGE, 32'h4);
        do_read(A_EDGE, 32'h4, "w1c_collide");
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL collide_irq: irq=%b expected=0", irq); end
        do_write(A_EDGE, 32'h4);
        do_read(A_EDGE, 32'h0, "w1c_bit2");
    endtask

    task automatic test_back_to_back();
        bus.address   = A_MASK;
        bus.writedata = 32'hFFFF_FFFF;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        exp_q.push_back(32'h1);
        name_q.push_back("rw_pre_write");
        tick();
        bus.read  = 1'b0;
        bus.write = 1'b0;
        sb_pop_compare();
        do_read(A_MASK, 32'hF, "mask_wide_write");
        do_write(A_DATA, 32'h0);
        do_write(A_RAW,  32'h0);
        do_read(A_DATA, 32'hF, "data_ro");
        do_read(A_RAW,  32'hF, "raw_ro");
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL b2b_irq: irq=%b expected=0", irq); end
    endtask

    task automatic test_reset_mid();
        in_port = 4'b0111;
        tick(12);
        do_read(A_EDGE, 32'h8, "fall_edge");
        tick();
        n_cmp++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL fall_irq: irq=%b expected=1", irq); end
        in_port = 4'b0110;
        tick(7);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL async_irq: irq=%b expected=0", irq); end
        n_cmp++;
        if (bus.readdata !== 32'h0) begin n_err++; $display("FAIL async_rd: readdata=%h expected=0", bus.readdata); end
        tick(2);
        reset_n = 1'b1;
        do_read(A_DATA, 32'h0, "rst_data");
        do_read(A_RAW,  32'h0, "rst_raw");
        tick(12);
        do_read(A_DATA, 32'h6, "rst_data_settled");
        do_read(A_MASK, 32'h0, "rst_mask");
        do_read(A_EDGE, 32'h0, "rst_edge");
        n_cmp++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL rst_irq: irq=%b expected=0", irq); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n       = 1'b0;
        in_port       = 4'b1010;
        bus.address   = 2'd0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = 32'h0;

        test_reset();
        test_rise();
        test_glitch();
        test_irq();
        test_simul_clear();
        test_back_to_back();
        test_reset_mid();

        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
